sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
Sequencer for the Sobel line-buffer/3x3-window datapath. Accepts a raster pixel stream through a valid/ready handshake. Generates line-buffer write enables and addresses, plus window shift strobes. Tracks column and row position, flags when the 3x3 window holds a full interior neighbourhood, and applies back-pressure when the downstream consumer stalls. Sits between the pixel source and the line buffers / convolution kernel in the Sobel top level.

Parameters:
IMG_WIDTH, 256, pixels per row (>=3)
IMG_HEIGHT, 256, rows per frame (>=3)
COL_W, 8, width of column counter/address, >= clog2(IMG_WIDTH)
ROW_W, 8, width of row counter, >= clog2(IMG_HEIGHT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle frame start request
in_valid  in  1  source has pixel
in_ready  out  1  controller accepts pixel this cycle
out_ready  in  1  kernel consumes window
lb_wr_en  out  1  line-buffer write strobe (= accept)
lb_addr  out  COL_W  line-buffer address (= current column)
win_shift  out  1  shift 3x3 window registers (= accept)
win_valid  out  1  window holds interior neighbourhood
win_row  out  ROW_W  centre-pixel row of valid window
win_col  out  COL_W  centre-pixel column of valid window
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, async): state=IDLE; col=0, row=0; win_valid=0, win_row=0, win_col=0, frame_done=0, busy=0.
- accept = in_valid & in_ready. lb_wr_en, win_shift and lb_addr are combinational from accept/col.
- States:
  - IDLE: in_ready=0. start -> PRIME, clears col/row.
  - PRIME: rows 0-1. in_ready=1. Accepting the last pixel of row 1 (col=IMG_WIDTH-1, row=1) -> STREAM.
  - STREAM: in_ready = !(win_valid & !out_ready). Accepting the last pixel of the last row -> FLUSH.
  - FLUSH: in_ready=0. When win_valid=0, or win_valid&out_ready -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- busy=1 in every state except IDLE.
- start is ignored outside IDLE.
- Counters: advance on accept only. col increments and wraps IMG_WIDTH-1 -> 0. row increments on col wrap. No advance after the last pixel.
- Window qualification:
  - On accept with row>=2 and col>=2: next cycle win_valid=1, win_row=row-1, win_col=col-1.
  - Border positions never raise win_valid.
  - Windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- win_valid hold: win_valid and its coordinates hold stable until out_ready=1.
- Window replacement: if out_ready=1 in the same cycle as a new qualifying accept, win_valid stays 1 with the new coordinates. Otherwise it clears to 0.
- Latency: pixel accept -> win_valid = 1 cycle. Maximum throughput is 1 pixel/clock with out_ready held high.
- Stall: while win_valid&!out_ready, in_ready=0. No line-buffer write and no shift occur, so the datapath is frozen.
- Mid-frame reset: async return to IDLE. Partial frame is discarded; the next start restarts at (0,0).
- in_valid while in_ready=0 has no effect. The source must hold its data.

Test Plan:
- Reset/idle: rst low for 3 cycles, then high, in_valid=1 and no start -> in_ready=0, busy=0, win_valid=0, no lb_wr_en.
- Full frame, IMG_WIDTH=5, IMG_HEIGHT=4, continuous in_valid and out_ready:
  - start then 20 pixels -> exactly 6 win_valid cycles.
  - Coordinates in order (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - First win_valid 1 cycle after the accept at row 2, col 2.
  - frame_done pulses once, then busy=0.
- Back-pressure: same frame, out_ready=0 for 4 cycles at the first win_valid -> in_ready=0 for those 4 cycles, win_row/win_col held at (1,1), no lb_wr_en/win_shift. Resumes with no window lost (still 6 total).
- Source gaps: in_valid toggled 1/0 every cycle -> identical window sequence and lb_addr sequence 0..4 per row. Frame completes after 20 accepts.
- Mid-frame reset: rst low after 9 accepts -> async IDLE with col/row=0. Then start plus a full 20-pixel frame -> normal 6-window result.
- start ignored: start pulses during STREAM -> no counter reset. Frame completes with 6 windows and one frame_done.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the Sobel line-buffer / 3x3 window datapath: raster position tracking,
// line-buffer write/shift strobes, interior-window qualification and consumer back-pressure.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int COL_W      = 8,
  parameter int ROW_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             lb_wr_en,
  output logic [COL_W-1:0] lb_addr,
  output logic             win_shift,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             row_end;
  logic             frame_end;
  logic             win_qual;

  // A pending window the consumer has not taken freezes the whole datapath.
  assign in_ready  = (state == PRIME) || ((state == STREAM) && !(win_valid && !out_ready));
  assign accept    = in_valid && in_ready;
  assign lb_wr_en  = accept;
  assign win_shift = accept;
  assign lb_addr   = col;

  assign row_end   = (col == COL_LAST);
  assign frame_end = row_end && (row == ROW_LAST);
  assign win_qual  = accept && (row >= ROW_TWO) && (col >= COL_TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = PRIME;
      end
      PRIME: begin
        if (accept && row_end && (row == ROW_ONE)) state_nxt = STREAM;
      end
      STREAM: begin
        if (accept && frame_end) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!win_valid || out_ready) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position counters freeze on the final pixel until the next start clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (accept && !frame_end) begin
      if (row_end) begin
        col <= '0;
        row <= row + ROW_ONE;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // The window centre lags the newest pixel by one row and one column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_qual) begin
      win_valid <= 1'b1;
      win_row   <= row - ROW_ONE;
      win_col   <= col - COL_W'(1);
    end else if (out_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 5x4 frame: directed vector table,
// directed multi-cycle sequences and randomized handshakes against a raster-count reference model.
module tb_sobel_window_ctrl;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int TOTAL = W * H;
  localparam int NWIN  = (W - 2) * (H - 2);

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       lb_wr_en;
  logic [7:0] lb_addr;
  logic       win_shift;
  logic       win_valid;
  logic [7:0] win_row;
  logic [7:0] win_col;
  logic       busy;
  logic       frame_done;

  sobel_window_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (8),
    .ROW_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_addr   (lb_addr),
    .win_shift (win_shift),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: pixels accepted so far, pending window, frame activity.
  int m_n;
  bit m_busy;
  bit m_wv;
  bit m_done;
  int m_wr;
  int m_wc;
  int m_widx;
  int fd_count;
  bit fd_seen;
  int exp_r[$];
  int exp_c[$];

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       st;
    logic       rdy;
    logic       bsy;
    logic       wr;
    logic [7:0] addr;
    logic       wv;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_n    = 0;
    m_busy = 0;
    m_wv   = 0;
    m_done = 0;
    m_wr   = 0;
    m_wc   = 0;
  endtask

  // Drive one cycle, check against the model at the falling edge, then advance the model.
  task automatic applyStimulus(input logic iv, input logic ordy, input logic st);
    bit rdy, acc, was_busy;
    int r, c;
    in_valid  = iv;
    out_ready = ordy;
    start     = st;
    @(negedge clk);
    rdy = m_busy && (m_n < TOTAL) && !(m_wv && !ordy);
    acc = rdy && iv;
    checkOutput("in_ready", 32'(in_ready), 32'(rdy));
    checkOutput("lb_wr_en", 32'(lb_wr_en), 32'(acc));
    checkOutput("win_shift", 32'(win_shift), 32'(acc));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("win_valid", 32'(win_valid), 32'(m_wv));
    if (acc) checkOutput("lb_addr", 32'(lb_addr), 32'(m_n % W));
    if (m_wv) begin
      checkOutput("win_row", 32'(win_row), 32'(m_wr));
      checkOutput("win_col", 32'(win_col), 32'(m_wc));
    end
    if (m_wv && ordy) begin
      if (m_widx < exp_r.size()) begin
        checkOutput("order_row", 32'(win_row), 32'(exp_r[m_widx]));
        checkOutput("order_col", 32'(win_col), 32'(exp_c[m_widx]));
      end else begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL extra_window: got index %0d expected below %0d", m_widx, exp_r.size());
      end
      m_widx++;
    end
    if (frame_done) begin
      fd_count++;
      fd_seen = 1;
    end
    r = m_n / W;
    c = m_n % W;
    was_busy = m_busy;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_busy && (m_n == TOTAL) && (!m_wv || ordy)) begin
      m_done = 1;
    end
    if (acc && (r >= 2) && (c >= 2)) begin
      m_wv = 1;
      m_wr = r - 1;
      m_wc = c - 1;
    end else if (ordy) begin
      m_wv = 0;
    end
    if (acc) m_n++;
    if (st && !was_busy) begin
      m_busy = 1;
      m_n    = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_win_valid", 32'(win_valid), 32'd0);
    rst = 1'b1;
    modelReset();
  endtask

  // mode 0 continuous, 1 stall at first window, 2 alternating source, 3 random, 4 stray starts
  task automatic runFrame(input int mode);
    int  cyc;
    int  stall_left;
    bit  seen_first;
    bit  tgl;
    logic iv, ordy, st;
    m_widx     = 0;
    fd_count   = 0;
    fd_seen    = 0;
    stall_left = 0;
    seen_first = 0;
    tgl        = 1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    cyc = 0;
    while (!fd_seen && cyc < 400) begin
      iv   = 1'b1;
      ordy = 1'b1;
      st   = 1'b0;
      case (mode)
        1: begin
          if (!seen_first && m_wv) begin
            seen_first = 1;
            stall_left = 4;
          end
          if (stall_left > 0) begin
            ordy       = 1'b0;
            stall_left--;
            out_ready  = 1'b0;
            in_valid   = 1'b1;
            #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_wr_en", 32'(lb_wr_en), 32'd0);
            checkOutput("stall_shift", 32'(win_shift), 32'd0);
            checkOutput("stall_row", 32'(win_row), 32'd1);
            checkOutput("stall_col", 32'(win_col), 32'd1);
          end
        end
        2: begin
          iv  = tgl;
          tgl = !tgl;
        end
        3: begin
          iv   = ($urandom % 4) != 0;
          ordy = ($urandom % 3) != 0;
        end
        4: st = (m_n == 12) || (m_n == 16);
        default: ;
      endcase
      applyStimulus(iv, ordy, st);
      cyc++;
    end
    if (!fd_seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL frame_timeout: got no frame_done expected one within 400 cycles");
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("windows_per_frame", 32'(m_widx), 32'(NWIN));
    checkOutput("frame_done_count", 32'(fd_count), 32'd1);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic midFrameReset();
    int cyc;
    m_widx = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    cyc = 0;
    while (m_n < 9 && cyc < 100) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      cyc++;
    end
    checkOutput("mid_accepts", 32'(m_n), 32'd9);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_win_valid", 32'(win_valid), 32'd0);
    checkOutput("mid_lb_addr", 32'(lb_addr), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
      end

    //            iv    ordy  st    rdy   bsy   wr    addr  wv
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0};

    doReset();
    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      start     = vecs[i].st;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      checkOutput($sformatf("vec%0d_lb_wr_en", i), 32'(lb_wr_en), 32'(vecs[i].wr));
      checkOutput($sformatf("vec%0d_lb_addr", i), 32'(lb_addr), 32'(vecs[i].addr));
      checkOutput($sformatf("vec%0d_win_valid", i), 32'(win_valid), 32'(vecs[i].wv));
      @(posedge clk);
      #1;
    end

    doReset();
    runFrame(0);
    runFrame(1);
    runFrame(2);
    runFrame(4);
    midFrameReset();
    runFrame(0);
    for (int k = 0; k < 4; k++) runFrame(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
